tilexy_link_arb: RTL and testbench
==================================

// Module: tileXY_link_arb
// PURPOSE
// - Credit-based round-robin arbiter for one outgoing X/Y mesh link of a tile write-request node.
// - Shares the link among NREQ sources (local injection, pass-through queues) and tracks downstream 8-entry queue space.
// - Issues at most one request per cycle on a registered link output.
// - Provides anti-starvation aging and a flush/quiesce handshake used before tile reconfiguration.
// PARAMETERS
// NREQ     3    number of requesters; index 0 = local injection
// W        655  request word width (wrreq layout, bits 654:0)
// CREDITS  8    downstream queue depth = initial credit count
// AGE_MAX  15   wait cycles before a requester is force-prioritised
// PORTS
// clk             in   1         clock, rising edge
// rst_n           in   1         asynchronous, active-low reset
// req_valid       in   NREQ      requester i has a word pending; held until granted
// req_data        in   NREQ*W    request words, slice i = bits [i*W +: W]
// req_grant       out  NREQ      one-hot combinational grant; word i consumed this cycle
// link_valid      out  1         registered: link_data valid this cycle
// link_data       out  W         registered granted word
// credit_ret      in   1         downstream freed one entry (1-cycle pulse, max 1/cycle)
// credits         out  4         current credit count, 0..CREDITS
// flush_req       in   1         level: stop granting and drain
// flush_done      out  1         level: no grants, link idle, credits==CREDITS
// cred_err        out  1         sticky: credit_ret received while credits==CREDITS
// BEHAVIOUR
// Reset (rst_n=0, async): credits=CREDITS, rr_ptr=0, all ages=0, state=RUN.
// - Outputs during reset: link_valid=0, link_data=0, req_grant=0, flush_done=0, cred_err=0.
// Grant rule (combinational), evaluated only in state RUN:
// - can_send = (credits!=0); a same-cycle credit_ret does not enable a grant at credits==0.
// - If any valid requester has age>=AGE_MAX, grant the lowest such index.
// - Otherwise grant the first valid index at or after rr_ptr, in cyclic order.
// - No grant when !can_send or state!=RUN.
// On grant g: link_data<=req_data[g], link_valid<=1, rr_ptr<=(g+1)%NREQ, age[g]<=0.
// - Latency: granted word appears on link exactly 1 cycle after req_grant.
// With no grant: link_valid<=0; link_data holds its value.
// Aging: each valid, ungranted requester increments age, saturating at AGE_MAX.
// - age[i] is cleared on grant or when req_valid[i]=0.
// Credit counter: credits <= credits - grant_any + credit_ret.
// - Simultaneous grant and return: count unchanged.
// - credit_ret at credits==CREDITS with no grant: count stays CREDITS, cred_err<=1 (sticky until reset).
// - A grant is never issued at credits==0, so the counter cannot underflow.
// State machine:
// - RUN: normal arbitration. flush_req=1 -> DRAIN, taking effect the following cycle.
//   - A grant made in the cycle flush_req rises is still honoured.
// - DRAIN: no grants. Leave to DONE when credits==CREDITS and link_valid==0.
//   - flush_req=0 in DRAIN -> RUN.
// - DONE: flush_done=1, no grants. flush_req=0 -> RUN; flush_done drops the same cycle.
// Reset mid-operation: any in-flight link word and credit state are discarded; reset values apply immediately.
// TESTING
// T1: reset, then req_valid=3'b111 for 3 cycles with credit_ret tied to send.
//     -> grants 0,1,2 in order; link_data equals each word 1 cycle later; credits stay 8.
// T2: req_valid=3'b001 for 9 cycles, no credit_ret.
//     -> 8 grants, credits 8->0; 9th cycle req_grant=0.
//     -> one credit_ret pulse: credits=1, then one more grant, credits=0.
// T3: req_valid[1], req_valid[2] continuously valid; req_valid[0] valid; credits limited to 1 per 2 cycles.
//     -> requester 0 granted within AGE_MAX+NREQ cycles; age[0] resets to 0 on that grant.
// T4: 3 words in flight (credits=5), assert flush_req.
//     -> no further grants; flush_done=1 the cycle after the third credit_ret.
//     -> deassert flush_req: flush_done=0 and grants resume next cycle.
// T5: credit_ret pulse at credits=8 with no traffic.
//     -> credits stays 8; cred_err=1 and remains 1 until rst_n is asserted.
// T6: assert rst_n=0 asynchronously mid-burst with link_valid=1.
//     -> link_valid=0 and credits=8 without waiting for a clock edge.
//     -> first grant after release goes to requester 0.

Source files
------------

// File: rtl/tilexy_link_arb.sv
// Credit-based round-robin arbiter for one outgoing X/Y mesh link.
// Ages waiting requesters and supports a flush/quiesce handshake.
module tilexy_link_arb #(
    parameter int NREQ    = 3,
    parameter int W       = 655,
    parameter int CREDITS = 8,
    parameter int AGE_MAX = 15
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NREQ-1:0]   req_valid,
    input  logic [NREQ*W-1:0] req_data,
    output logic [NREQ-1:0]   req_grant,
    output logic              link_valid,
    output logic [W-1:0]      link_data,
    input  logic              credit_ret,
    output logic [3:0]        credits,
    input  logic              flush_req,
    output logic              flush_done,
    output logic              cred_err
);

    localparam int AW = $clog2(AGE_MAX + 1);
    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic [3:0] CRED_MAX = 4'(CREDITS);
    localparam logic [AW-1:0] AGE_SAT = AW'(AGE_MAX);
    localparam logic [PW-1:0] LAST = PW'(NREQ - 1);

    typedef enum logic [1:0] {
        S_RUN,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t                   r_state;
    state_t                   w_state_nxt;
    logic [PW-1:0]            r_ptr;
    logic [NREQ-1:0][AW-1:0]  r_age;
    logic [3:0]               r_credits;
    logic                     r_link_valid;
    logic [W-1:0]             r_link_data;
    logic                     r_cred_err;

    logic                     w_aged_hit;
    logic [PW-1:0]            w_aged_idx;
    logic                     w_rr_hit;
    logic [PW-1:0]            w_rr_idx;
    logic [PW-1:0]            w_gidx;
    logic                     w_can;
    logic                     w_grant_any;
    logic                     w_idle;

    // Aged requesters beat round-robin; loops run downward so the
    // lowest index (or nearest to the pointer) wins.
    always_comb begin
        w_aged_hit = 1'b0;
        w_aged_idx = '0;
        w_rr_hit   = 1'b0;
        w_rr_idx   = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (req_valid[i] && (r_age[i] >= AGE_SAT)) begin
                w_aged_hit = 1'b1;
                w_aged_idx = PW'(i);
            end
        end
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (req_valid[(int'(r_ptr) + k) % NREQ]) begin
                w_rr_hit = 1'b1;
                w_rr_idx = PW'((int'(r_ptr) + k) % NREQ);
            end
        end
    end

    assign w_gidx      = w_aged_hit ? w_aged_idx : w_rr_idx;
    assign w_can       = rst_n && (r_state == S_RUN) && (r_credits != 4'd0);
    assign w_grant_any = w_can && (w_aged_hit || w_rr_hit);
    assign w_idle      = (r_credits == CRED_MAX) && !r_link_valid;

    always_comb begin
        req_grant = '0;
        if (w_grant_any) begin
            req_grant[w_gidx] = 1'b1;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            S_RUN:   if (flush_req) w_state_nxt = S_DRAIN;
            S_DRAIN: begin
                if (!flush_req) begin
                    w_state_nxt = S_RUN;
                end else if (w_idle) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE:  if (!flush_req) w_state_nxt = S_RUN;
            default: w_state_nxt = S_RUN;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_RUN;
            r_ptr        <= '0;
            r_link_valid <= 1'b0;
            r_link_data  <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_link_valid <= w_grant_any;
            if (w_grant_any) begin
                r_link_data <= req_data[int'(w_gidx)*W +: W];
                r_ptr       <= (w_gidx == LAST) ? '0 : w_gidx + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_age <= '0;
        end else begin
            for (int i = 0; i < NREQ; i++) begin
                if (!req_valid[i] || (w_grant_any && (w_gidx == PW'(i)))) begin
                    r_age[i] <= '0;
                end else if (r_age[i] != AGE_SAT) begin
                    r_age[i] <= r_age[i] + 1'b1;
                end
            end
        end
    end

    // A return with a full counter and no grant is a downstream bug.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_credits  <= CRED_MAX;
            r_cred_err <= 1'b0;
        end else if (w_grant_any && !credit_ret) begin
            r_credits <= r_credits - 4'd1;
        end else if (!w_grant_any && credit_ret) begin
            if (r_credits == CRED_MAX) begin
                r_cred_err <= 1'b1;
            end else begin
                r_credits <= r_credits + 4'd1;
            end
        end
    end

    assign link_valid = r_link_valid;
    assign link_data  = r_link_data;
    assign credits    = r_credits;
    assign cred_err   = r_cred_err;
    assign flush_done = flush_req &&
                        ((r_state == S_DONE) ||
                         ((r_state == S_DRAIN) && w_idle));

endmodule

// File: tb/tb_tilexy_link_arb.sv
// Scoreboard bench for tilexy_link_arb: grants checked inline,
// link words checked against a queue of expected words.
module tb_tilexy_link_arb;

    localparam int NREQ = 3;
    localparam int W    = 655;

    logic              clk;
    logic              rst_n;
    logic [NREQ-1:0]   req_valid;
    logic [NREQ*W-1:0] req_data;
    logic [NREQ-1:0]   req_grant;
    logic              link_valid;
    logic [W-1:0]      link_data;
    logic              credit_ret;
    logic [3:0]        credits;
    logic              flush_req;
    logic              flush_done;
    logic              cred_err;

    logic [W-1:0] dw [NREQ];
    logic [W-1:0] q [$];
    int checks;
    int failures;

    assign req_data = {dw[2], dw[1], dw[0]};

    tilexy_link_arb dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_data   (req_data),
        .req_grant  (req_grant),
        .link_valid (link_valid),
        .link_data  (link_data),
        .credit_ret (credit_ret),
        .credits    (credits),
        .flush_req  (flush_req),
        .flush_done (flush_done),
        .cred_err   (cred_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [W-1:0] mk(input int i, input int t);
        logic [W-1:0] v;
        v = '0;
        for (int k = 0; k < 20; k++) begin
            v[k*32 +: 32] = 32'hC0DE_0000 ^ 32'(i << 12) ^ 32'(t << 4) ^ 32'(k);
        end
        v[W-1 -: 15] = 15'(t * 7 + i);
        return v;
    endfunction

    // Link monitor: every valid link word must match the oldest expectation.
    always @(negedge clk) begin
        logic [W-1:0] e;
        if (rst_n && link_valid) begin
            checks++;
            if (q.size() == 0) begin
                failures++;
                $display("FAIL link_unexpected got=%h exp=none", link_data);
            end else begin
                e = q.pop_front();
                if (link_data !== e) begin
                    failures++;
                    $display("FAIL link_data got=%h exp=%h", link_data, e);
                end
            end
        end
    end

    task automatic refill;
        for (int n = 0; n < 12; n++) begin
            @(posedge clk); #1;
            if (credits == 4'd8) begin
                credit_ret = 1'b0;
                return;
            end
            credit_ret = 1'b1;
        end
        credit_ret = 1'b0;
        checks++;
        failures++;
        $display("FAIL refill_timeout got=%0d exp=8", credits);
    endtask

    task automatic test_reset;
        req_valid = '1;
        #12;
        checks++;
        if (req_grant !== 3'b000) begin
            failures++; $display("FAIL rst_grant got=%b exp=000", req_grant);
        end
        checks++;
        if (link_valid !== 1'b0) begin
            failures++; $display("FAIL rst_lv got=%b exp=0", link_valid);
        end
        checks++;
        if (link_data !== '0) begin
            failures++; $display("FAIL rst_ld got=%h exp=0", link_data);
        end
        checks++;
        if (credits !== 4'd8) begin
            failures++; $display("FAIL rst_credits got=%0d exp=8", credits);
        end
        checks++;
        if (flush_done !== 1'b0 || cred_err !== 1'b0) begin
            failures++;
            $display("FAIL rst_flags got=%b%b exp=00", flush_done, cred_err);
        end
        req_valid = '0;
        #1 rst_n = 1'b1;
    endtask

    task automatic test_round_robin;
        logic [NREQ-1:0] e;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            req_valid  = '1;
            credit_ret = 1'b1;
            for (int j = 0; j < NREQ; j++) dw[j] = mk(j, k + 1);
            @(negedge clk);
            e = 3'b001 << k;
            checks++;
            if (req_grant !== e) begin
                failures++; $display("FAIL rr_grant got=%b exp=%b", req_grant, e);
            end
            q.push_back(dw[k]);
            checks++;
            if (credits !== 4'd8) begin
                failures++; $display("FAIL rr_credits got=%0d exp=8", credits);
            end
        end
        @(posedge clk); #1;
        req_valid  = '0;
        credit_ret = 1'b0;
        @(negedge clk);
        checks++;
        if (credits !== 4'd8 || cred_err !== 1'b0) begin
            failures++;
            $display("FAIL rr_end got=%0d/%b exp=8/0", credits, cred_err);
        end
    endtask

    task automatic test_credit_exhaust;
        logic [NREQ-1:0] e;
        for (int k = 1; k <= 9; k++) begin
            @(posedge clk); #1;
            req_valid = 3'b001;
            dw[0] = mk(0, 10 + k);
            @(negedge clk);
            checks++;
            if (credits !== 4'(9 - k)) begin
                failures++; $display("FAIL ce_credits got=%0d exp=%0d", credits, 9 - k);
            end
            e = (k <= 8) ? 3'b001 : 3'b000;
            checks++;
            if (req_grant !== e) begin
                failures++; $display("FAIL ce_grant got=%b exp=%b", req_grant, e);
            end
            if (k <= 8) q.push_back(dw[0]);
        end
        @(posedge clk); #1;
        credit_ret = 1'b1;
        @(negedge clk);
        checks++;
        if (req_grant !== 3'b000) begin
            failures++; $display("FAIL ce_same_cyc got=%b exp=000", req_grant);
        end
        @(posedge clk); #1;
        credit_ret = 1'b0;
        @(negedge clk);
        checks++;
        if (credits !== 4'd1 || req_grant !== 3'b001) begin
            failures++;
            $display("FAIL ce_one got=%0d/%b exp=1/001", credits, req_grant);
        end
        q.push_back(dw[0]);
        @(posedge clk); #1;
        req_valid = '0;
        @(negedge clk);
        checks++;
        if (credits !== 4'd0) begin
            failures++; $display("FAIL ce_zero got=%0d exp=0", credits);
        end
        refill();
    endtask

    task automatic test_aging;
        int seq [3] = '{1, 2, 0};
        logic [NREQ-1:0] e;
        for (int k = 0; k < 8; k++) begin
            @(posedge clk); #1;
            req_valid = 3'b001;
            dw[0] = mk(0, 30 + k);
            @(negedge clk);
            checks++;
            if (req_grant !== 3'b001) begin
                failures++; $display("FAIL ag_drain got=%b exp=001", req_grant);
            end
            q.push_back(dw[0]);
        end
        repeat (16) begin
            @(posedge clk); #1;
        end
        @(negedge clk);
        checks++;
        if (req_grant !== 3'b000) begin
            failures++; $display("FAIL ag_starved got=%b exp=000", req_grant);
        end
        @(posedge clk); #1;
        credit_ret = 1'b1;
        @(posedge clk); #1;
        credit_ret = 1'b0;
        req_valid  = 3'b011;
        dw[1] = mk(1, 50);
        @(negedge clk);
        checks++;
        if (req_grant !== 3'b001) begin
            failures++; $display("FAIL ag_force got=%b exp=001", req_grant);
        end
        q.push_back(dw[0]);
        for (int n = 0; n < 7; n++) begin
            @(posedge clk); #1;
            req_valid  = 3'b111;
            credit_ret = (n % 2 == 0);
            @(negedge clk);
            e = (n % 2 == 1) ? (3'b001 << seq[n/2]) : 3'b000;
            checks++;
            if (req_grant !== e) begin
                failures++; $display("FAIL ag_rr n=%0d got=%b exp=%b", n, req_grant, e);
            end
            if (n % 2 == 1) q.push_back(dw[seq[n/2]]);
            if (n == 6) begin
                checks++;
                if (dut.r_age[0] !== 4'd0) begin
                    failures++; $display("FAIL ag_clear got=%0d exp=0", dut.r_age[0]);
                end
            end
        end
        @(posedge clk); #1;
        req_valid  = '0;
        credit_ret = 1'b0;
        refill();
    endtask

    task automatic test_flush;
        int seq [3] = '{1, 2, 0};
        logic [NREQ-1:0] e;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            req_valid = 3'b111;
            flush_req = (k == 2);
            @(negedge clk);
            e = 3'b001 << seq[k];
            checks++;
            if (req_grant !== e) begin
                failures++; $display("FAIL fl_grant got=%b exp=%b", req_grant, e);
            end
            q.push_back(dw[seq[k]]);
        end
        @(posedge clk); #1;
        @(negedge clk);
        checks++;
        if (req_grant !== 3'b000 || credits !== 4'd5 || flush_done !== 1'b0) begin
            failures++;
            $display("FAIL fl_drain got=%b/%0d/%b exp=000/5/0", req_grant, credits, flush_done);
        end
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            credit_ret = 1'b1;
            @(negedge clk);
            checks++;
            if (req_grant !== 3'b000 || flush_done !== 1'b0) begin
                failures++;
                $display("FAIL fl_ret got=%b/%b exp=000/0", req_grant, flush_done);
            end
        end
        @(posedge clk); #1;
        credit_ret = 1'b0;
        @(negedge clk);
        checks++;
        if (flush_done !== 1'b1 || credits !== 4'd8 || link_valid !== 1'b0) begin
            failures++;
            $display("FAIL fl_done got=%b/%0d/%b exp=1/8/0", flush_done, credits, link_valid);
        end
        @(posedge clk); #1;
        @(negedge clk);
        checks++;
        if (flush_done !== 1'b1 || req_grant !== 3'b000) begin
            failures++;
            $display("FAIL fl_hold got=%b/%b exp=1/000", flush_done, req_grant);
        end
        @(posedge clk); #1;
        flush_req = 1'b0;
        @(negedge clk);
        checks++;
        if (flush_done !== 1'b0 || req_grant !== 3'b000) begin
            failures++;
            $display("FAIL fl_release got=%b/%b exp=0/000", flush_done, req_grant);
        end
        @(posedge clk); #1;
        @(negedge clk);
        checks++;
        if (req_grant !== 3'b010) begin
            failures++; $display("FAIL fl_resume got=%b exp=010", req_grant);
        end
        q.push_back(dw[1]);
        @(posedge clk); #1;
        req_valid = '0;
        refill();
    endtask

    task automatic test_cred_err;
        @(negedge clk);
        checks++;
        if (credits !== 4'd8 || cred_err !== 1'b0) begin
            failures++;
            $display("FAIL ce_pre got=%0d/%b exp=8/0", credits, cred_err);
        end
        @(posedge clk); #1;
        credit_ret = 1'b1;
        @(posedge clk); #1;
        credit_ret = 1'b0;
        @(negedge clk);
        checks++;
        if (credits !== 4'd8 || cred_err !== 1'b1) begin
            failures++;
            $display("FAIL err_set got=%0d/%b exp=8/1", credits, cred_err);
        end
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            checks++;
            if (cred_err !== 1'b1) begin
                failures++; $display("FAIL err_sticky got=%b exp=1", cred_err);
            end
        end
    endtask

    task automatic test_async_reset;
        @(posedge clk); #1;
        req_valid = 3'b111;
        @(negedge clk);
        checks++;
        if (req_grant !== 3'b100) begin
            failures++; $display("FAIL ar_g2 got=%b exp=100", req_grant);
        end
        q.push_back(dw[2]);
        @(posedge clk); #1;
        @(negedge clk);
        checks++;
        if (req_grant !== 3'b001 || link_valid !== 1'b1) begin
            failures++;
            $display("FAIL ar_pre got=%b/%b exp=001/1", req_grant, link_valid);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (link_valid !== 1'b0 || credits !== 4'd8) begin
            failures++;
            $display("FAIL ar_async got=%b/%0d exp=0/8", link_valid, credits);
        end
        checks++;
        if (req_grant !== 3'b000 || cred_err !== 1'b0) begin
            failures++;
            $display("FAIL ar_flags got=%b/%b exp=000/0", req_grant, cred_err);
        end
        q.delete();
        req_valid = '0;
        @(posedge clk); #3;
        rst_n = 1'b1;
        @(posedge clk); #1;
        req_valid = 3'b111;
        @(negedge clk);
        checks++;
        if (req_grant !== 3'b001) begin
            failures++; $display("FAIL ar_first got=%b exp=001", req_grant);
        end
        q.push_back(dw[0]);
        @(posedge clk); #1;
        req_valid = '0;
        repeat (2) @(negedge clk);
    endtask

    initial begin
        checks     = 0;
        failures   = 0;
        rst_n      = 1'b0;
        req_valid  = '0;
        credit_ret = 1'b0;
        flush_req  = 1'b0;
        for (int i = 0; i < NREQ; i++) dw[i] = mk(i, 0);
        test_reset();
        test_round_robin();
        test_credit_exhaust();
        test_aging();
        test_flush();
        test_cred_err();
        test_async_reset();
        checks++;
        if (q.size() != 0) begin
            failures++; $display("FAIL sb_leftover got=%0d exp=0", q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
